// File: rtl/wfi_power_seq.sv
// WFI low-power sequencer: stalls fetch, drains the pipeline, releases the HFOSC
// request, and on wake re-requests the clock and waits for a settled oscillator.
module wfi_power_seq #(
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned WAKE_TIMEOUT  = 255,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wfi_req,
  input  logic             pipe_busy,
  input  logic             wake_irq,
  input  logic             osc_ready,
  output logic             clk_req,
  output logic             fetch_ce,
  output logic             wfi_ack,
  output logic             sleeping,
  output logic             osc_fault,
  output logic [CNT_W-1:0] sleep_cnt
);

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd1;
  localparam logic [2:0] ST_SLEEP  = 3'd2;
  localparam logic [2:0] ST_WAKE   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  localparam logic [3:0]       DRAIN_LOAD  = 4'(DRAIN_CYCLES - 1);
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       WAKE_LIMIT  = 8'(WAKE_TIMEOUT);
  localparam logic [CNT_W-1:0] SLEEP_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] SLEEP_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_r, state_s;
  logic [3:0]       drain_cnt_r, drain_cnt_s;
  logic [3:0]       settle_cnt_r, settle_cnt_s;
  logic [7:0]       wake_cnt_r, wake_cnt_s, wake_inc_s;
  logic             osc_meta_r, osc_rdy_s;
  logic             rdy_seen_r, rdy_seen_s;
  logic             wfi_pend_r, wfi_pend_s;
  logic             ack_s, fault_s;
  logic [CNT_W-1:0] sleep_cnt_s;

  // Two-flop synchronizer for the oscillator ready level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_meta_r <= 1'b0;
      osc_rdy_s  <= 1'b0;
    end else begin
      osc_meta_r <= osc_ready;
      osc_rdy_s  <= osc_meta_r;
    end
  end

  assign wake_inc_s = wake_cnt_r + 8'd1;

  // Next-state and counter logic
  always_comb begin
    state_s      = state_r;
    drain_cnt_s  = drain_cnt_r;
    settle_cnt_s = settle_cnt_r;
    wake_cnt_s   = wake_cnt_r;
    rdy_seen_s   = 1'b0;
    wfi_pend_s   = wfi_pend_r;
    ack_s        = 1'b0;
    fault_s      = osc_fault;
    sleep_cnt_s  = sleep_cnt;
    case (state_r)
      ST_RUN: begin
        // A request still visible during its own ack cycle is the old WFI, not a new one
        if (wfi_req && !wfi_ack) begin
          if (wake_irq) begin
            ack_s = 1'b1;
          end else begin
            state_s     = ST_DRAIN;
            drain_cnt_s = DRAIN_LOAD;
            wfi_pend_s  = 1'b1;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (wake_irq) begin
          state_s    = ST_RUN;
          ack_s      = 1'b1;
          wfi_pend_s = 1'b0;
        end else if ((drain_cnt_r == 4'd0) && !pipe_busy) begin
          state_s     = ST_SLEEP;
          sleep_cnt_s = {CNT_W{1'b0}};
        end else if (drain_cnt_r != 4'd0) begin
          drain_cnt_s = drain_cnt_r - 4'd1;
        end else begin
          drain_cnt_s = drain_cnt_r;
        end
      end
      ST_SLEEP: begin
        if (sleep_cnt != SLEEP_MAX) begin
          sleep_cnt_s = sleep_cnt + SLEEP_ONE;
        end else begin
          sleep_cnt_s = sleep_cnt;
        end
        if (wake_irq) begin
          state_s    = ST_WAKE;
          wake_cnt_s = 8'd0;
        end else begin
          state_s = ST_SLEEP;
        end
      end
      ST_WAKE: begin
        // rdy_seen only counts samples taken inside WAKE, so a stale level cannot pass alone
        rdy_seen_s = osc_rdy_s;
        wake_cnt_s = wake_inc_s;
        if (osc_rdy_s && rdy_seen_r) begin
          state_s      = ST_SETTLE;
          settle_cnt_s = SETTLE_LOAD;
        end else if (wake_inc_s == WAKE_LIMIT) begin
          fault_s      = 1'b1;
          state_s      = ST_SETTLE;
          settle_cnt_s = SETTLE_LOAD;
        end else begin
          state_s = ST_WAKE;
        end
      end
      ST_SETTLE: begin
        // Once faulted the ready level is not trusted, so it cannot bounce us back to WAKE
        if (!osc_rdy_s && !osc_fault) begin
          state_s    = ST_WAKE;
          wake_cnt_s = 8'd0;
        end else if (settle_cnt_r == 4'd0) begin
          state_s    = ST_RUN;
          ack_s      = wfi_pend_r;
          wfi_pend_s = 1'b0;
        end else begin
          settle_cnt_s = settle_cnt_r - 4'd1;
        end
      end
      default: begin
        state_s    = ST_WAKE;
        wake_cnt_s = 8'd0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_WAKE;
      drain_cnt_r  <= 4'd0;
      settle_cnt_r <= 4'd0;
      wake_cnt_r   <= 8'd0;
      rdy_seen_r   <= 1'b0;
      wfi_pend_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      drain_cnt_r  <= drain_cnt_s;
      settle_cnt_r <= settle_cnt_s;
      wake_cnt_r   <= wake_cnt_s;
      rdy_seen_r   <= rdy_seen_s;
      wfi_pend_r   <= wfi_pend_s;
    end
  end

  // Registered outputs decoded from the next state so they line up with state_r
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_req   <= 1'b1;
      fetch_ce  <= 1'b0;
      wfi_ack   <= 1'b0;
      sleeping  <= 1'b0;
      osc_fault <= 1'b0;
      sleep_cnt <= {CNT_W{1'b0}};
    end else begin
      clk_req   <= (state_s != ST_SLEEP);
      fetch_ce  <= (state_s == ST_RUN);
      wfi_ack   <= ack_s;
      sleeping  <= (state_s == ST_SLEEP);
      osc_fault <= fault_s;
      sleep_cnt <= sleep_cnt_s;
    end
  end

endmodule

// File: tb/tb_wfi_power_seq.sv
// Directed self-checking bench for wfi_power_seq (WAKE_TIMEOUT shortened to 8).
module tb_wfi_power_seq;

  logic        clk;
  logic        rst_n;
  logic        wfi_req;
  logic        pipe_busy;
  logic        wake_irq;
  logic        osc_ready;
  logic        clk_req;
  logic        fetch_ce;
  logic        wfi_ack;
  logic        sleeping;
  logic        osc_fault;
  logic [15:0] sleep_cnt;

  int checks = 0;
  int errors = 0;

  wfi_power_seq #(
    .DRAIN_CYCLES (4),
    .SETTLE_CYCLES(2),
    .WAKE_TIMEOUT (8),
    .CNT_W        (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wfi_req  (wfi_req),
    .pipe_busy(pipe_busy),
    .wake_irq (wake_irq),
    .osc_ready(osc_ready),
    .clk_req  (clk_req),
    .fetch_ce (fetch_ce),
    .wfi_ack  (wfi_ack),
    .sleeping (sleeping),
    .osc_fault(osc_fault),
    .sleep_cnt(sleep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Release reset at a negedge and follow the wake sequence: fetch_ce rises after the 6th edge
  task automatic release_and_boot(input string tag);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (fetch_ce !== (k >= 6)) begin
        errors++;
        $display("FAIL %s_fetch_ce edge %0d: got %b want %b", tag, k, fetch_ce, (k >= 6));
      end
      checks++;
      if (clk_req !== 1'b1 || wfi_ack !== 1'b0) begin
        errors++;
        $display("FAIL %s_req_ack edge %0d: got clk_req=%b wfi_ack=%b want 1/0", tag, k, clk_req, wfi_ack);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wfi_req = 1'b0; pipe_busy = 1'b0; wake_irq = 1'b0; osc_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({clk_req, fetch_ce, wfi_ack, sleeping, osc_fault} !== 5'b10000 || sleep_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: got req/ce/ack/slp/flt=%b%b%b%b%b cnt=%0d want 10000 cnt=0",
               clk_req, fetch_ce, wfi_ack, sleeping, osc_fault, sleep_cnt);
    end
    @(negedge clk);
    release_and_boot("boot");
  endtask

  task automatic test_sleep_wake();
    int waited;
    int acks;
    wfi_req = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_ce !== 1'b0 || clk_req !== 1'b1 || wfi_ack !== 1'b0) begin
      errors++;
      $display("FAIL drain_entry: got ce=%b req=%b ack=%b want 0 1 0", fetch_ce, clk_req, wfi_ack);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (clk_req !== 1'b1 || sleeping !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold %0d: got req=%b slp=%b want 1 0", k, clk_req, sleeping);
      end
    end
    @(negedge clk);
    checks++;
    if (clk_req !== 1'b0 || sleeping !== 1'b1) begin
      errors++;
      $display("FAIL sleep_entry: got req=%b slp=%b want 0 1", clk_req, sleeping);
    end
    repeat (9) @(negedge clk);
    wake_irq = 1'b1;
    @(negedge clk);
    wake_irq = 1'b0;
    checks++;
    if (clk_req !== 1'b1 || sleeping !== 1'b0 || sleep_cnt !== 16'd10 || fetch_ce !== 1'b0) begin
      errors++;
      $display("FAIL wake_entry: got req=%b slp=%b cnt=%0d ce=%b want 1 0 10 0",
               clk_req, sleeping, sleep_cnt, fetch_ce);
    end
    waited = 0;
    acks = 0;
    while (fetch_ce !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
      if (wfi_ack === 1'b1) acks++;
    end
    checks++;
    if (waited !== 4 || acks !== 1 || wfi_ack !== 1'b1) begin
      errors++;
      $display("FAIL wake_to_run: got cycles=%0d acks=%0d ack_at_run=%b want 4 1 1", waited, acks, wfi_ack);
    end
    @(negedge clk);
    wfi_req = 1'b0;
    checks++;
    if (wfi_ack !== 1'b0 || fetch_ce !== 1'b1 || sleep_cnt !== 16'd10) begin
      errors++;
      $display("FAIL post_ack_hold: got ack=%b ce=%b cnt=%0d want 0 1 10", wfi_ack, fetch_ce, sleep_cnt);
    end
  endtask

  task automatic test_wfi_nop();
    wfi_req = 1'b1; wake_irq = 1'b1;
    @(negedge clk);
    checks++;
    if (wfi_ack !== 1'b1 || fetch_ce !== 1'b1 || clk_req !== 1'b1) begin
      errors++;
      $display("FAIL nop_ack: got ack=%b ce=%b req=%b want 1 1 1", wfi_ack, fetch_ce, clk_req);
    end
    @(negedge clk);
    wfi_req = 1'b0; wake_irq = 1'b0;
    checks++;
    if (wfi_ack !== 1'b0 || fetch_ce !== 1'b1 || clk_req !== 1'b1) begin
      errors++;
      $display("FAIL nop_no_retrigger: got ack=%b ce=%b req=%b want 0 1 1", wfi_ack, fetch_ce, clk_req);
    end
  endtask

  task automatic test_drain_abort();
    wfi_req = 1'b1; pipe_busy = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 5) begin
        checks++;
        if (fetch_ce !== 1'b0 || sleeping !== 1'b0 || clk_req !== 1'b1 || wfi_ack !== 1'b0) begin
          errors++;
          $display("FAIL busy_drain %0d: got ce=%b slp=%b req=%b ack=%b want 0 0 1 0",
                   c, fetch_ce, sleeping, clk_req, wfi_ack);
        end
        if (c == 5) wake_irq = 1'b1;
      end else begin
        checks++;
        if (fetch_ce !== 1'b1 || clk_req !== 1'b1 || wfi_ack !== (c == 6)) begin
          errors++;
          $display("FAIL abort_run %0d: got ce=%b req=%b ack=%b want 1 1 %b",
                   c, fetch_ce, clk_req, wfi_ack, (c == 6));
        end
      end
    end
    wfi_req = 1'b0; pipe_busy = 1'b0; wake_irq = 1'b0;
  endtask

  task automatic wait_sleep(input string tag);
    int n;
    n = 0;
    while (sleeping !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sleeping !== 1'b1 || n !== 5) begin
      errors++;
      $display("FAIL %s_reach_sleep: got slp=%b after %0d cycles want 1 after 5", tag, sleeping, n);
    end
  endtask

  task automatic test_wake_timeout();
    wfi_req = 1'b1;
    wait_sleep("tmo");
    osc_ready = 1'b0;
    repeat (4) @(negedge clk);
    wake_irq = 1'b1;
    @(negedge clk);
    wake_irq = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (osc_fault !== 1'b0 || fetch_ce !== 1'b0 || clk_req !== 1'b1) begin
        errors++;
        $display("FAIL tmo_wait %0d: got flt=%b ce=%b req=%b want 0 0 1", k, osc_fault, fetch_ce, clk_req);
      end
    end
    @(negedge clk);
    checks++;
    if (osc_fault !== 1'b1 || fetch_ce !== 1'b0) begin
      errors++;
      $display("FAIL tmo_fault: got flt=%b ce=%b want 1 0", osc_fault, fetch_ce);
    end
    @(negedge clk);
    checks++;
    if (fetch_ce !== 1'b0) begin
      errors++;
      $display("FAIL tmo_settle: got ce=%b want 0", fetch_ce);
    end
    @(negedge clk);
    checks++;
    if (fetch_ce !== 1'b1 || wfi_ack !== 1'b1) begin
      errors++;
      $display("FAIL tmo_run: got ce=%b ack=%b want 1 1", fetch_ce, wfi_ack);
    end
    @(negedge clk);
    wfi_req = 1'b0;
    osc_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (osc_fault !== 1'b1 || fetch_ce !== 1'b1 || wfi_ack !== 1'b0) begin
      errors++;
      $display("FAIL tmo_sticky: got flt=%b ce=%b ack=%b want 1 1 0", osc_fault, fetch_ce, wfi_ack);
    end
  endtask

  task automatic test_reset_in_sleep();
    wfi_req = 1'b1;
    wait_sleep("rst");
    repeat (3) @(negedge clk);
    checks++;
    if (sleep_cnt !== 16'd3 || clk_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: got cnt=%0d req=%b want 3 0", sleep_cnt, clk_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_req, fetch_ce, wfi_ack, sleeping, osc_fault} !== 5'b10000 || sleep_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_async: got req/ce/ack/slp/flt=%b%b%b%b%b cnt=%0d want 10000 cnt=0",
               clk_req, fetch_ce, wfi_ack, sleeping, osc_fault, sleep_cnt);
    end
    wfi_req = 1'b0;
    @(negedge clk);
    release_and_boot("reboot");
  endtask

  initial begin
    test_reset();
    test_sleep_wake();
    test_wfi_nop();
    test_drain_abort();
    test_wake_timeout();
    test_reset_in_sleep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
